// File: rtl/spi_cmd_ctrl.sv
// Command/response controller behind the SPI slave: decodes one command byte,
// runs a read/write/strobe action and hands an 18-bit response back for the next frame.
module spi_cmd_ctrl #(
  parameter int NREG    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 tx_ready,
  output logic [17:0]          tx_data,
  output logic                 load,
  input  logic [NREG*16-1:0]   stat_words,
  output logic [5:0]           ctrl_reg,
  output logic                 ctrl_strobe,
  output logic                 busy,
  output logic [3:0]           err_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  state_t        state;
  logic          rx_valid_d;
  logic [7:0]    cmd;
  logic [TW-1:0] to_cnt;
  logic [15:0]   words [8];

  // Pad the status bank out to the full 3-bit address space so the read mux never indexes past NREG.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_words
      if (gi < NREG) begin : g_used
        assign words[gi] = stat_words[16*gi +: 16];
      end else begin : g_pad
        assign words[gi] = 16'h0000;
      end
    end
  endgenerate

  logic       new_byte;
  logic [1:0] op;
  logic [5:0] arg;
  logic [2:0] addr;
  logic       rd_ok;
  logic       overrun_err;
  logic       rd_err;
  logic       to_err;
  logic       err_evt;

  assign new_byte    = rx_valid & ~rx_valid_d;
  assign op          = cmd[7:6];
  assign arg         = cmd[5:0];
  assign addr        = cmd[2:0];
  assign rd_ok       = ({1'b0, addr} < 4'(NREG));
  assign overrun_err = new_byte && (state != IDLE);
  assign rd_err      = (state == EXEC) && (op == 2'b01) && !rd_ok;
  assign to_err      = (state == WAIT) && !tx_ready && (to_cnt == TO_LAST);
  assign err_evt     = overrun_err | rd_err | to_err;

  assign load = (state == WAIT) & tx_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rx_valid_d  <= 1'b0;
      cmd         <= 8'h00;
      to_cnt      <= '0;
      tx_data     <= 18'h00000;
      ctrl_reg    <= 6'h00;
      ctrl_strobe <= 1'b0;
      err_count   <= 4'h0;
    end else begin
      rx_valid_d  <= rx_valid;
      ctrl_strobe <= 1'b0;
      // Coincident error sources still count as a single event.
      if (err_evt && (err_count != 4'hF))
        err_count <= err_count + 4'h1;

      case (state)
        IDLE: begin
          if (new_byte) begin
            cmd   <= rx_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          state  <= WAIT;
          to_cnt <= '0;
          case (op)
            2'b00: tx_data <= {2'b00, 8'h00, cmd};
            2'b01: tx_data <= rd_ok ? {2'b01, words[addr]} : {2'b11, 8'hEE, cmd};
            2'b10: begin
              ctrl_reg <= arg;
              tx_data  <= {2'b10, 8'h00, cmd};
            end
            default: begin
              ctrl_strobe <= 1'b1;
              tx_data     <= {2'b10, 8'h00, cmd};
            end
          endcase
        end
        WAIT: begin
          if (tx_ready)
            state <= IDLE;
          else if (to_cnt == TO_LAST)
            state <= IDLE;
          else
            to_cnt <= to_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command/response controller sitting directly behind the SPI slave in the `sys_clk` domain. It consumes each received 8-bit command byte (`rx_data`/`rx_valid`) and decodes it. It then executes read, write or strobe actions on local registers, and hands an 18-bit response word to the SPI slave via `tx_data`/`load`. The SPI master shifts that response out on the next SPI frame.

## Interface
Parameters:
- `NREG`, default 4: number of 16-bit status words readable over SPI; legal range 1..8.
- `TIMEOUT`, default 1024: maximum `sys_clk` cycles spent waiting for `tx_ready` before the response is dropped; must be ≥ 2.

Ports:
- `sys_clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: last command byte from the SPI slave.
- `rx_valid` in 1: a new byte is signalled by a 0→1 transition.
- `tx_ready` in 1: high while the SPI slave is idle and accepts `load`.
- `tx_data` out 18: response word, {tag[1:0], payload[15:0]}.
- `load` out 1: one-cycle request to the SPI slave to latch `tx_data`.
- `stat_words` in NREG*16: status word i is `stat_words[16*i +: 16]`.
- `ctrl_reg` out 6: control register written by the WRITE command.
- `ctrl_strobe` out 1: one-cycle pulse issued by the STROBE command.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_count` out 4: saturating error counter.

## Operation
- Command byte: `op = rx_data[7:6]`, `arg = rx_data[5:0]`.
- Rising-edge detect: register `rx_valid_d`. `new_byte = rx_valid & ~rx_valid_d`.
- FSM states: IDLE, EXEC, WAIT.
  - IDLE → EXEC on `new_byte`. The byte is captured into `cmd` on the same edge.
  - EXEC → WAIT, unconditionally, after one cycle. In EXEC, the op is executed and the response is registered into `tx_data` at the exiting edge.
  - WAIT → IDLE when `tx_ready` = 1. `load` is high for that cycle only.
  - WAIT → IDLE on timeout (see below). No `load` is issued and `err_count` increments.
- Op decode and response:
  - 00 NOP: `tx_data` = {2'b00, 8'h00, cmd}.
  - 01 READ: `addr = arg[2:0]`.
    - If `addr < NREG`: `tx_data` = {2'b01, stat_words[addr]}, sampled at the EXEC edge.
    - Otherwise: error response, and `err_count` increments.
  - 10 WRITE: `ctrl_reg <= arg` at the EXEC edge. `tx_data` = {2'b10, 8'h00, cmd}.
  - 11 STROBE: `ctrl_strobe` is high for exactly the cycle following EXEC. `tx_data` = {2'b10, 8'h00, cmd}.
  - Error response: {2'b11, 8'hEE, cmd}.
- `load` is combinational: `(state == WAIT) & tx_ready`.
- `tx_data` holds its value from EXEC until the next EXEC. It is stable for the whole WAIT state.
- Timeout: a counter clears on entry to WAIT and increments each WAIT cycle with `tx_ready` = 0. When it reaches `TIMEOUT-1` with `tx_ready` still 0, the FSM goes to IDLE.
- Overrun: if `new_byte` occurs while the state is EXEC or WAIT, the byte is dropped and `err_count` increments. The current transaction continues unaffected.
- `err_count` saturates at 15 and never wraps. Simultaneous error sources in one cycle add 1 in total.

## Timing
- Reset values: `tx_data` = 0, `load` = 0, `ctrl_reg` = 0, `ctrl_strobe` = 0, `busy` = 0, `err_count` = 0, state IDLE, `rx_valid_d` = 0, timeout counter 0.
- Latency, with `rx_valid` sampled high at edge k (and low at k-1):
  - EXEC during cycle k→k+1.
  - Response and side effects are visible after edge k+1.
  - Earliest `load` is during cycle k+1→k+2, if `tx_ready` = 1.
  - `busy` is high from after edge k until after the edge at which `load` is seen.
- Back-to-back: a new byte is accepted in the first IDLE cycle, so minimum spacing is 3 cycles.
- Reset mid-transaction: all state clears immediately. A pending response is discarded and no `load` is issued.
- `rx_valid` held high does not retrigger. It must return to 0 and rise again.

## Test plan
- **READ:** `stat_words[1]` = 16'hBEEF, send byte 8'h41, `tx_ready` = 1 → `tx_data` = 18'h1BEEF, `load` high for 1 cycle, 2 cycles after the `rx_valid` rise.
- **Out-of-range READ:** NREG = 4, send byte 8'h46 → `tx_data` = 18'h3EE46, `err_count` = 1.
- **WRITE then STROBE:** send 8'hA5 → `ctrl_reg` = 6'h25 and `tx_data` = 18'h200A5. Then send 8'hC0 → exactly one `ctrl_strobe` pulse, `tx_data` = 18'h200C0.
- **Held off, then timeout:** hold `tx_ready` = 0 after a NOP byte 8'h12 → no `load`, `busy` stays high. Release `tx_ready` at cycle 10 → `load` is issued. Repeat with `tx_ready` low for `TIMEOUT` cycles → return to IDLE with no `load`, `err_count` +1.
- **Overrun and saturation:** pulse `rx_valid` twice, 1 cycle apart → the first byte executes, the second is dropped and counted. Drive 20 errors → `err_count` = 15.
- **Async reset:** assert `rst` while in WAIT → all outputs return to reset values with no `load`. The next command works normally.
